mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, synchronous-read RAM between the core's instruction-fetch port and its load/store port. Each requester uses a valid/ready request channel and receives a fixed one-cycle-latency response. Data accesses have priority, and a starvation counter guarantees forward progress for fetch. The block sits between the pipeline's fetch/memory stages and the RAM macro that replaces the dual-ported memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of both requester ports
- DATA_W, 32, word width
- RAM_AW, 14, RAM word-index width (16384 words)
- STARVE_LIMIT, 4, consecutive cycles fetch may be denied before it is forced through

Ports (clock and reset: one clock; reset is asynchronous and active-high, named `clock` and `reset`):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- inst_req_valid  in  1  fetch request present
- inst_req_ready  out  1  fetch request accepted this cycle
- inst_req_addr  in  ADDR_W  fetch byte address
- inst_resp_valid  out  1  fetch data valid
- inst_resp_data  out  DATA_W  fetched word
- data_req_valid  in  1  load/store request present
- data_req_ready  out  1  load/store accepted this cycle
- data_req_addr  in  ADDR_W  load/store byte address
- data_req_wen  in  1  1 = store, 0 = load
- data_req_wdata  in  DATA_W  store data
- data_resp_valid  out  1  load data or store acknowledge valid
- data_resp_rdata  out  DATA_W  load data; 0 on store acknowledge
- ram_en  out  1  RAM access this cycle
- ram_wen  out  1  RAM write
- ram_addr  out  RAM_AW  RAM word index
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en && !ram_wen

## Operation
- At most one grant per cycle. Grant is combinational from the current valids and the starvation state.
- Default priority: data over inst.
- Forced fetch: when starve_cnt == STARVE_LIMIT and inst_req_valid is high, inst wins even if data_req_valid is high.
- starve_cnt behaviour:
  - increments, saturating at STARVE_LIMIT, each cycle inst_req_valid && !inst_req_ready;
  - clears on an inst grant or when inst_req_valid is low.
- On a grant:
  - ram_en = 1;
  - ram_addr = addr[RAM_AW+1:2]. Low two bits are ignored; upper bits beyond RAM_AW+1 are ignored, so addresses wrap;
  - ram_wen = data_req_wen (data grant only); ram_wdata = data_req_wdata.
- With no grant: ram_en = 0, ram_wen = 0, ram_addr and ram_wdata = 0.
- Owner register (NONE/INST/DATA) records the winner and the access type (read/write) for the following cycle.
- Response cycle:
  - owner INST: inst_resp_valid = 1, inst_resp_data = ram_rdata;
  - owner DATA, read: data_resp_valid = 1, data_resp_rdata = ram_rdata;
  - owner DATA, write: data_resp_valid = 1, data_resp_rdata = 0.
- Responses have no backpressure; requesters must accept them.
- Response data outputs are 0 whenever the matching resp_valid is low.

## Timing
- Reset values:
  - owner = NONE, starve_cnt = 0;
  - all resp_valid, req_ready, ram_en and ram_wen are 0;
  - all data outputs are 0.
- Request accepted in cycle N (valid && ready high at edge N) → response valid in cycle N+1 only. Fixed latency 1.
- Back-to-back grants allowed every cycle; throughput is 1 access/cycle total.
- Simultaneous valid on both ports: data wins unless the starvation override applies. The loser's ready stays 0 and it must hold its request stable.
- Store followed by a load to the same word in the next cycle returns the new data, since the RAM writes at edge N.
- Reset asserted mid-operation: any pending response is dropped, with no resp_valid in the cycle after reset deasserts.

## Structure
- Package mem_arb_pkg holds:
  - owner_t enum {OWN_NONE, OWN_INST, OWN_DATA};
  - default constants for DATA_W, RAM_AW and STARVE_LIMIT.
- One sub-module, mem_arb_starve_ctr: saturating counter with clear, exposing a `force` output when the count is at the limit.
- The arbiter top holds the grant logic, the owner/type register and the response muxing.

## Test plan
- Fetch only, addr 0x00, 0x04, 0x08 on consecutive cycles with RAM preloaded with 0x11, 0x22, 0x33 → ready every cycle; inst_resp_data 0x11, 0x22, 0x33 one cycle later each.
- Store 0xDEADBEEF to 0x100, then load 0x100 next cycle → data_resp_valid both cycles; rdata 0 then 0xDEADBEEF.
- Both ports valid continuously, data back-to-back loads, STARVE_LIMIT = 4 → data granted 4 cycles, inst granted on cycle 5, pattern repeats.
- Address 0x0001_0004 with RAM_AW = 14 → ram_addr = 1 (wrap); address 0x103 → ram_addr = 0x40.
- Reset pulsed in the cycle after an inst grant → inst_resp_valid stays 0, all outputs 0, starve_cnt 0.
- Idle with no valids for 10 cycles → ram_en 0 throughout, no resp_valid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and default sizing for the memory-port arbiter.
//   owner_t       - which requester owns the RAM response in the next cycle
//   DEF_*         - default parameter values used by the arbiter and its bench
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam int unsigned DEF_ADDR_W       = 32;
  localparam int unsigned DEF_DATA_W       = 32;
  localparam int unsigned DEF_RAM_AW       = 14;
  localparam int unsigned DEF_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// mem_arb_starve_ctr: saturating starvation counter with synchronous clear.
//   clock, reset  - rising-edge clock, asynchronous active-high reset
//   inc           - count one more denied cycle (saturates at LIMIT)
//   clr           - return to zero; has priority over inc
//   cnt           - current count
//   force_grant   - high while the count sits at LIMIT
module mem_arb_starve_ctr #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             force_grant
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_C)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_grant = (cnt == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous-read RAM between the
// instruction-fetch port and the load/store port.
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   inst_req_*            - fetch request channel (valid/ready, byte address)
//   inst_resp_*           - fetch response, one cycle after acceptance
//   data_req_*            - load/store request channel (valid/ready, addr, wen, wdata)
//   data_resp_*           - load data or store acknowledge (rdata 0 on stores)
//   ram_*                 - RAM macro port; ram_rdata valid the cycle after a read
//   dbg_owner             - owner/response state register
//   dbg_starve_cnt        - fetch starvation count
//
// Handshake: a request transfers on a rising edge where valid && ready are both
// high. ready is combinational from the current valids and starvation state and
// never depends on the requester waiting for it; a requester that sees ready low
// must hold valid and its payload stable. Responses have no backpressure and
// appear exactly one cycle after the transfer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned RAM_AW       = DEF_RAM_AW,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              inst_req_valid,
  output logic                              inst_req_ready,
  input  logic [ADDR_W-1:0]                 inst_req_addr,
  output logic                              inst_resp_valid,
  output logic [DATA_W-1:0]                 inst_resp_data,
  input  logic                              data_req_valid,
  output logic                              data_req_ready,
  input  logic [ADDR_W-1:0]                 data_req_addr,
  input  logic                              data_req_wen,
  input  logic [DATA_W-1:0]                 data_req_wdata,
  output logic                              data_resp_valid,
  output logic [DATA_W-1:0]                 data_resp_rdata,
  output logic                              ram_en,
  output logic                              ram_wen,
  output logic [RAM_AW-1:0]                 ram_addr,
  output logic [DATA_W-1:0]                 ram_wdata,
  input  logic [DATA_W-1:0]                 ram_rdata,
  output owner_t                            dbg_owner,
  output logic [$clog2(STARVE_LIMIT+1)-1:0] dbg_starve_cnt
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic   inst_grant;
  logic   data_grant;
  logic   starve_force;
  owner_t owner_q;
  owner_t owner_d;
  logic   wr_q;
  logic   wr_d;

  // Byte-offset bits and address bits above the RAM are intentionally dropped,
  // so addresses wrap modulo the RAM size.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_req_addr[1:0], inst_req_addr[ADDR_W-1:RAM_AW+2],
                              data_req_addr[1:0], data_req_addr[ADDR_W-1:RAM_AW+2]};

  // Data wins by default; a starved fetch overrides it once the counter saturates.
  always_comb begin
    inst_grant = inst_req_valid && (!data_req_valid || starve_force);
    data_grant = data_req_valid && !inst_grant;
  end

  assign inst_req_ready = inst_grant;
  assign data_req_ready = data_grant;

  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (inst_grant) begin
      ram_en   = 1'b1;
      ram_addr = inst_req_addr[RAM_AW+1:2];
    end else if (data_grant) begin
      ram_en    = 1'b1;
      ram_wen   = data_req_wen;
      ram_addr  = data_req_addr[RAM_AW+1:2];
      ram_wdata = data_req_wdata;
    end
  end

  // Count cycles where fetch waits; any cycle fetch is idle or granted restarts it.
  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT),
    .CNT_W (CNT_W)
  ) u_starve_ctr (
    .clock       (clock),
    .reset       (reset),
    .inc         (inst_req_valid && !inst_grant),
    .clr         (!inst_req_valid || inst_grant),
    .cnt         (dbg_starve_cnt),
    .force_grant (starve_force)
  );

  // Owner/type register: next-state logic.
  always_comb begin
    owner_d = OWN_NONE;
    wr_d    = 1'b0;
    if (inst_grant) begin
      owner_d = OWN_INST;
    end else if (data_grant) begin
      owner_d = OWN_DATA;
      wr_d    = data_req_wen;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q <= OWN_NONE;
      wr_q    <= 1'b0;
    end else begin
      owner_q <= owner_d;
      wr_q    <= wr_d;
    end
  end

  assign dbg_owner = owner_q;

  // Response muxing: data outputs are forced to 0 when their valid is low.
  always_comb begin
    inst_resp_valid = 1'b0;
    inst_resp_data  = '0;
    data_resp_valid = 1'b0;
    data_resp_rdata = '0;
    case (owner_q)
      OWN_INST: begin
        inst_resp_valid = 1'b1;
        inst_resp_data  = ram_rdata;
      end
      OWN_DATA: begin
        data_resp_valid = 1'b1;
        data_resp_rdata = wr_q ? '0 : ram_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clock;
  logic        reset;
  logic        inst_req_valid;
  logic        inst_req_ready;
  logic [31:0] inst_req_addr;
  logic        inst_resp_valid;
  logic [31:0] inst_resp_data;
  logic        data_req_valid;
  logic        data_req_ready;
  logic [31:0] data_req_addr;
  logic        data_req_wen;
  logic [31:0] data_req_wdata;
  logic        data_resp_valid;
  logic [31:0] data_resp_rdata;
  logic        ram_en;
  logic        ram_wen;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  owner_t      dbg_owner;
  logic [2:0]  dbg_starve_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Expected responses: {cycle the response must appear in, data}.
  logic [63:0] inst_exp_q[$];
  logic [63:0] data_exp_q[$];

  mem_port_arbiter dut (
    .clock           (clock),
    .reset           (reset),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_req_addr   (inst_req_addr),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_data  (inst_resp_data),
    .data_req_valid  (data_req_valid),
    .data_req_ready  (data_req_ready),
    .data_req_addr   (data_req_addr),
    .data_req_wen    (data_req_wen),
    .data_req_wdata  (data_req_wdata),
    .data_resp_valid (data_resp_valid),
    .data_resp_rdata (data_resp_rdata),
    .ram_en          (ram_en),
    .ram_wen         (ram_wen),
    .ram_addr        (ram_addr),
    .ram_wdata       (ram_wdata),
    .ram_rdata       (ram_rdata),
    .dbg_owner       (dbg_owner),
    .dbg_starve_cnt  (dbg_starve_cnt)
  );

  // ---------------- clock / reset / RAM model ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] mem [0:16383];

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
    ram_rdata = 32'h0;
  end

  always @(posedge clock) begin
    if (ram_en) begin
      if (ram_wen) mem[ram_addr] <= ram_wdata;
      else         ram_rdata     <= mem[ram_addr];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    inst_req_valid = 1'b0;
    inst_req_addr  = 32'h0;
    data_req_valid = 1'b0;
    data_req_addr  = 32'h0;
    data_req_wen   = 1'b0;
    data_req_wdata = 32'h0;
  endtask

  task automatic drive_inst(input logic [31:0] addr, input logic [13:0] exp_idx, input logic [31:0] exp_data);
    @(negedge clock);
    set_idle();
    inst_req_valid = 1'b1;
    inst_req_addr  = addr;
    #1;
    check("inst_ready", 64'(inst_req_ready), 64'd1);
    check("inst_ram_addr", 64'(ram_addr), 64'(exp_idx));
    check("inst_ram_en_wen", 64'({ram_en, ram_wen}), 64'b10);
    inst_exp_q.push_back({32'(cyc + 1), exp_data});
  endtask

  task automatic drive_data(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                            input logic [13:0] exp_idx, input logic [31:0] exp_resp);
    @(negedge clock);
    set_idle();
    data_req_valid = 1'b1;
    data_req_addr  = addr;
    data_req_wen   = wen;
    data_req_wdata = wdata;
    #1;
    check("data_ready", 64'(data_req_ready), 64'd1);
    check("data_ram_addr", 64'(ram_addr), 64'(exp_idx));
    check("data_ram_en_wen", 64'({ram_en, ram_wen}), 64'({1'b1, wen}));
    if (wen) check("data_ram_wdata", 64'(ram_wdata), 64'(wdata));
    data_exp_q.push_back({32'(cyc + 1), exp_resp});
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    set_idle();
    #1;
    check("idle_ram_en", 64'(ram_en), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [63:0] e;
    if (inst_resp_valid) begin
      if (inst_exp_q.size() == 0) begin
        check("inst_resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = inst_exp_q.pop_front();
        check("inst_resp_cycle", 64'(cyc), 64'(e[63:32]));
        check("inst_resp_data", 64'(inst_resp_data), 64'(e[31:0]));
      end
    end else begin
      check("inst_resp_data_idle", 64'(inst_resp_data), 64'd0);
    end
    if (data_resp_valid) begin
      if (data_exp_q.size() == 0) begin
        check("data_resp_unexpected", 64'd1, 64'd0);
      end else begin
        e = data_exp_q.pop_front();
        check("data_resp_cycle", 64'(cyc), 64'(e[63:32]));
        check("data_resp_rdata", 64'(data_resp_rdata), 64'(e[31:0]));
      end
    end else begin
      check("data_resp_rdata_idle", 64'(data_resp_rdata), 64'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  logic [9:0] inst_win_pat;

  initial begin
    set_idle();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_ready", 64'({inst_req_ready, data_req_ready}), 64'd0);
    check("rst_ram", 64'({ram_en, ram_wen}), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'd0);
    check("rst_resp_valid", 64'({inst_resp_valid, data_resp_valid}), 64'd0);
    check("rst_starve_cnt", 64'(dbg_starve_cnt), 64'd0);
    check("rst_owner", 64'(dbg_owner), 64'(OWN_NONE));
    reset = 1'b0;

    // Fetch stream 0x00, 0x04, 0x08 back to back.
    drive_inst(32'h0, 14'd0, 32'h11);
    drive_inst(32'h4, 14'd1, 32'h22);
    drive_inst(32'h8, 14'd2, 32'h33);
    idle_cycle();

    // Store then load to the same word on consecutive cycles.
    drive_data(32'h100, 1'b1, 32'hDEADBEEF, 14'h40, 32'h0);
    drive_data(32'h100, 1'b0, 32'h0,        14'h40, 32'hDEADBEEF);
    idle_cycle();

    // Address wrap and ignored byte offset.
    drive_inst(32'h0001_0004, 14'd1, 32'h22);
    drive_data(32'h103, 1'b0, 32'h0, 14'h40, 32'hDEADBEEF);
    idle_cycle();

    // Both ports valid continuously: four data grants then a forced fetch.
    inst_win_pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      set_idle();
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'h8;
      data_req_valid = 1'b1;
      data_req_addr  = 32'h4;
      #1;
      check("starve_cnt", 64'(dbg_starve_cnt), 64'(i % 5));
      check("starve_inst_ready", 64'(inst_req_ready), 64'(inst_win_pat[i]));
      check("starve_data_ready", 64'(data_req_ready), 64'(!inst_win_pat[i]));
      check("starve_ram_addr", 64'(ram_addr), inst_win_pat[i] ? 64'd2 : 64'd1);
      if (inst_win_pat[i]) inst_exp_q.push_back({32'(cyc + 1), 32'h33});
      else                 data_exp_q.push_back({32'(cyc + 1), 32'h22});
    end
    idle_cycle();

    // Reset asserted in the response cycle of a fetch: response is dropped.
    @(negedge clock);
    set_idle();
    inst_req_valid = 1'b1;
    inst_req_addr  = 32'h0;
    #1;
    check("pre_rst_inst_ready", 64'(inst_req_ready), 64'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    set_idle();
    #1;
    check("midrst_resp_valid", 64'({inst_resp_valid, data_resp_valid}), 64'd0);
    check("midrst_inst_data", 64'(inst_resp_data), 64'd0);
    check("midrst_ram", 64'({ram_en, ram_wen, ram_addr}), 64'd0);
    check("midrst_starve_cnt", 64'(dbg_starve_cnt), 64'd0);
    check("midrst_owner", 64'(dbg_owner), 64'(OWN_NONE));
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("postrst_resp_valid", 64'({inst_resp_valid, data_resp_valid}), 64'd0);

    // Idle for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      idle_cycle();
      check("idle_resp_valid", 64'({inst_resp_valid, data_resp_valid}), 64'd0);
    end

    repeat (2) @(negedge clock);
    #1;
    check("inst_exp_q_drained", 64'(inst_exp_q.size()), 64'd0);
    check("data_exp_q_drained", 64'(data_exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
